// File: rtl/fifo_rate_demo_if.sv
// Observation bundle of the FIFO rate demo: LEDs and debug outputs.
// master drives, slave (board or bench) observes.
interface fifo_rate_demo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [5:0]        leds;
    logic              err_flag;
    logic [4:0]        err_count;
    logic [ADDR_W:0]   fifo_level;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output leds, err_flag, err_count,
        output fifo_level, rx_valid, rx_data
    );

    modport slave (
        input leds, err_flag, err_count,
        input fifo_level, rx_valid, rx_data
    );
endinterface

// File: rtl/fifo_rate_demo.sv
// FIFO throughput demo: rate-divided writer/reader around a sync FIFO,
// sequence checker on the read side. ERR_INJECT_EN skips one value per pass.
module fifo_rate_demo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int WR_PERIOD = 4,
    parameter int RD_PERIOD = 1
) (
    input  logic clk,
    input  logic reset,
    fifo_rate_demo_if.master mon
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int WCW = (WR_PERIOD > 1) ? $clog2(WR_PERIOD) : 1;
    localparam int RCW = (RD_PERIOD > 1) ? $clog2(RD_PERIOD) : 1;
    localparam logic [WCW-1:0] WR_LAST = WCW'(WR_PERIOD - 1);
    localparam logic [RCW-1:0] RD_LAST = RCW'(RD_PERIOD - 1);
    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
    localparam logic [DATA_W-1:0] SKIP = ONE << (DATA_W - 1);

    logic [WCW-1:0]    wr_div;
    logic [RCW-1:0]    rd_div;
    logic              wr_tick;
    logic              rd_tick;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wr_seq;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] exp_seq;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              err_flag;
    logic [4:0]        err_count;
    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_tick = (wr_div == WR_LAST);
    assign rd_tick = (rd_div == RD_LAST);
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign push    = wr_tick & ~full;
    assign pop     = rd_tick & ~empty;

    // Rate dividers: count 0..PERIOD-1, tick on the last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_div <= '0;
            rd_div <= '0;
        end else begin
            wr_div <= wr_tick ? '0 : wr_div + 1'b1;
            rd_div <= rd_tick ? '0 : rd_div + 1'b1;
        end
    end

    // Word the writer pushes; optionally skips the mid-range value.
    always_comb begin
        wr_word = wr_seq;
`ifdef ERR_INJECT_EN
        if (wr_seq == SKIP) begin
            wr_word = SKIP + ONE;
        end
`endif
    end

    // Storage array; contents need no reset, pointers gate validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_word;
        end
    end

    // Pointers, occupancy and writer sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp     <= '0;
            rp     <= '0;
            level  <= '0;
            wr_seq <= '0;
        end else begin
            if (push) begin
                wp     <= wp + 1'b1;
                wr_seq <= wr_word + ONE;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Read port: registered data with a one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= pop;
            if (pop) begin
                rx_data <= mem[rp];
            end
        end
    end

    // Sequence checker; resynchronises to the received value each time.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_seq   <= '0;
            err_flag  <= 1'b0;
            err_count <= '0;
        end else if (rx_valid) begin
            exp_seq <= rx_data + ONE;
            if (rx_data != exp_seq) begin
                err_flag <= 1'b1;
                if (err_count != 5'd31) begin
                    err_count <= err_count + 5'd1;
                end
            end
        end
    end

    assign mon.leds       = ~{err_flag, rx_data[DATA_W-1 -: 5]};
    assign mon.err_flag   = err_flag;
    assign mon.err_count  = err_count;
    assign mon.fifo_level = level;
    assign mon.rx_valid   = rx_valid;
    assign mon.rx_data    = rx_data;
endmodule

// File: tb/tb_fifo_rate_demo.sv
// Bench for fifo_rate_demo: two instances (WR4/RD1 and WR1/RD4)
// checked against a queue-based scoreboard model.
module tb_fifo_rate_demo;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int checks = 0;
    int passes = 0;

`ifdef ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    fifo_rate_demo_if #(.DATA_W(8), .ADDR_W(4)) mon_a ();
    fifo_rate_demo_if #(.DATA_W(8), .ADDR_W(4)) mon_b ();

    fifo_rate_demo #(
        .DATA_W(8), .ADDR_W(4), .WR_PERIOD(4), .RD_PERIOD(1)
    ) dut_a (
        .clk(clk), .reset(rst_a), .mon(mon_a)
    );

    fifo_rate_demo #(
        .DATA_W(8), .ADDR_W(4), .WR_PERIOD(1), .RD_PERIOD(4)
    ) dut_b (
        .clk(clk), .reset(rst_b), .mon(mon_b)
    );

    always #5 clk = ~clk;

    // scoreboard model state, index 0 = dut_a, 1 = dut_b
    int WPER[2] = '{4, 1};
    int RPER[2] = '{1, 4};
    int wc[2];
    int rc[2];
    int ec[2];
    logic [7:0] sq[2];
    logic [7:0] rxd[2];
    logic [7:0] ex[2];
    bit rxv[2];
    bit ef[2];
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    task automatic model_edge(input int d, input logic r);
        int sz;
        bit pu;
        bit po;
        logic [7:0] v;
        sz = (d == 0) ? qa.size() : qb.size();
        if (r) begin
            if (d == 0) qa.delete();
            else qb.delete();
            wc[d] = 0; rc[d] = 0; ec[d] = 0;
            sq[d] = 0; rxd[d] = 0; ex[d] = 0;
            rxv[d] = 0; ef[d] = 0;
            return;
        end
        if (rxv[d]) begin
            if (rxd[d] != ex[d]) begin
                ef[d] = 1;
                if (ec[d] < 31) ec[d]++;
            end
            ex[d] = rxd[d] + 8'd1;
        end
        pu = (wc[d] == WPER[d] - 1) && (sz < 16);
        po = (rc[d] == RPER[d] - 1) && (sz > 0);
        rxv[d] = 0;
        if (po) begin
            rxd[d] = (d == 0) ? qa.pop_front() : qb.pop_front();
            rxv[d] = 1;
        end
        if (pu) begin
            v = sq[d];
            if (INJ && v == 8'h80) v = 8'h81;
            if (d == 0) qa.push_back(v);
            else qb.push_back(v);
            sq[d] = v + 8'd1;
        end
        wc[d] = (wc[d] == WPER[d] - 1) ? 0 : wc[d] + 1;
        rc[d] = (rc[d] == RPER[d] - 1) ? 0 : rc[d] + 1;
    endtask

    // one clock: model follows the edge, then settle to the falling edge
    task automatic step();
        @(posedge clk);
        model_edge(0, rst_a);
        model_edge(1, rst_b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 13; k++) begin
            step();
            checks++;
            if (mon_a.leds !== 6'h3F)
                $display("FAIL rst_leds got %h want 3f", mon_a.leds);
            else passes++;
            checks++;
            if (mon_a.fifo_level !== 5'd0)
                $display("FAIL rst_level got %0d want 0", mon_a.fifo_level);
            else passes++;
            checks++;
            if (mon_a.rx_valid !== 1'b0)
                $display("FAIL rst_rxv got %b want 0", mon_a.rx_valid);
            else passes++;
            checks++;
            if (mon_b.fifo_level !== 5'd0 || mon_b.rx_valid !== 1'b0)
                $display("FAIL rst_b got lvl %0d rxv %b want 0 0",
                         mon_b.fifo_level, mon_b.rx_valid);
            else passes++;
        end
    endtask

    task automatic test_first_push();
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) step();
            checks++;
            if (mon_a.fifo_level !== 5'(qa.size()))
                $display("FAIL fp_level k=%0d got %0d want %0d",
                         k, mon_a.fifo_level, qa.size());
            else passes++;
            checks++;
            if (mon_a.rx_valid !== rxv[0])
                $display("FAIL fp_rxv k=%0d got %b want %b",
                         k, mon_a.rx_valid, rxv[0]);
            else passes++;
            if (rxv[0]) begin
                checks++;
                if (mon_a.rx_data !== rxd[0])
                    $display("FAIL fp_rxd k=%0d got %h want %h",
                             k, mon_a.rx_data, rxd[0]);
                else passes++;
            end
            if (k == 4) begin
                checks++;
                if (mon_a.fifo_level !== 5'd1)
                    $display("FAIL fp_lvl4 got %0d want 1", mon_a.fifo_level);
                else passes++;
            end
            if (k == 5) begin
                checks++;
                if (mon_a.rx_valid !== 1'b1 || mon_a.rx_data !== 8'h00)
                    $display("FAIL fp_first got %b/%h want 1/00",
                             mon_a.rx_valid, mon_a.rx_data);
                else passes++;
            end
            if (k < 5) begin
                checks++;
                if (mon_a.rx_valid !== 1'b0)
                    $display("FAIL fp_early k=%0d got %b want 0",
                             k, mon_a.rx_valid);
                else passes++;
            end
            checks++;
            if (mon_a.fifo_level > 5'd1 || mon_a.err_flag !== 1'b0)
                $display("FAIL fp_bound got lvl %0d err %b want <=1 0",
                         mon_a.fifo_level, mon_a.err_flag);
            else passes++;
        end
    endtask

    task automatic test_full_stall();
        int got = 0;
        int cyc = 0;
        int maxl = 0;
        int full_cyc = 0;
        bit first = 1;
        logic [7:0] prev = 0;
        while (got < 300 && cyc < 3000) begin
            step();
            cyc++;
            checks++;
            if (mon_b.fifo_level !== 5'(qb.size()))
                $display("FAIL fs_level got %0d want %0d",
                         mon_b.fifo_level, qb.size());
            else passes++;
            checks++;
            if (mon_b.rx_valid !== rxv[1])
                $display("FAIL fs_rxv got %b want %b", mon_b.rx_valid, rxv[1]);
            else passes++;
            if (int'(mon_b.fifo_level) > maxl) maxl = int'(mon_b.fifo_level);
            if (mon_b.fifo_level == 5'd16) full_cyc++;
            if (mon_b.rx_valid === 1'b1) begin
                got++;
                checks++;
                if (mon_b.rx_data !== rxd[1])
                    $display("FAIL fs_rxd got %h want %h", mon_b.rx_data, rxd[1]);
                else passes++;
                if (!first && !(INJ && mon_b.rx_data == 8'h81)) begin
                    checks++;
                    if (mon_b.rx_data !== prev + 8'd1)
                        $display("FAIL fs_consec got %h want %h",
                                 mon_b.rx_data, prev + 8'd1);
                    else passes++;
                end
                first = 0;
                prev = mon_b.rx_data;
            end
            checks++;
            if (mon_b.err_count !== 5'(ec[1]))
                $display("FAIL fs_errcnt got %0d want %0d", mon_b.err_count, ec[1]);
            else passes++;
        end
        checks++;
        if (got < 300) $display("FAIL fs_timeout got %0d want 300 values", got);
        else passes++;
        checks++;
        if (maxl != 16) $display("FAIL fs_maxlevel got %0d want 16", maxl);
        else passes++;
        checks++;
        if (full_cyc < 100)
            $display("FAIL fs_hold_full got %0d want >=100 cycles", full_cyc);
        else passes++;
`ifndef ERR_INJECT_EN
        checks++;
        if (mon_b.err_count !== 5'd0)
            $display("FAIL fs_noerr got %0d want 0", mon_b.err_count);
        else passes++;
`endif
    endtask

    task automatic test_wrap();
        int got = 0;
        int cyc = 0;
        bit wrapped = 0;
        logic [7:0] prev = 0;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        while (got < 300 && cyc < 1500) begin
            step();
            cyc++;
            checks++;
            if (mon_a.err_flag !== ef[0] || mon_a.leds[5] !== ~ef[0])
                $display("FAIL wr_err got %b/%b want %b", mon_a.err_flag,
                         mon_a.leds[5], ef[0]);
            else passes++;
            if (mon_a.rx_valid === 1'b1) begin
                got++;
                checks++;
                if (mon_a.rx_data !== rxd[0])
                    $display("FAIL wr_rxd got %h want %h", mon_a.rx_data, rxd[0]);
                else passes++;
                checks++;
                if (mon_a.leds[4:0] !== ~rxd[0][7:3])
                    $display("FAIL wr_leds got %h want %h",
                             mon_a.leds[4:0], ~rxd[0][7:3]);
                else passes++;
                if (prev == 8'hFF && mon_a.rx_data == 8'h00) wrapped = 1;
                prev = mon_a.rx_data;
            end
        end
        checks++;
        if (got < 300) $display("FAIL wr_timeout got %0d want 300 values", got);
        else passes++;
        checks++;
        if (!wrapped) $display("FAIL wr_wrap got none want ff->00");
        else passes++;
`ifndef ERR_INJECT_EN
        checks++;
        if (mon_a.err_flag !== 1'b0 || mon_a.err_count !== 5'd0)
            $display("FAIL wr_noerr got %b/%0d want 0/0",
                     mon_a.err_flag, mon_a.err_count);
        else passes++;
`endif
    endtask

`ifdef ERR_INJECT_EN
    task automatic test_err_inject();
        int cyc = 0;
        int n = 0;
        bit found = 0;
        logic [7:0] prev = 0;
        logic [7:0] want;
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        while (!found && cyc < 800) begin
            step();
            cyc++;
            if (mon_a.rx_valid === 1'b1) begin
                if (prev == 8'h7F) begin
                    found = 1;
                    checks++;
                    if (mon_a.rx_data !== 8'h81)
                        $display("FAIL ei_skip got %h want 81", mon_a.rx_data);
                    else passes++;
                end else begin
                    checks++;
                    if (mon_a.err_flag !== 1'b0)
                        $display("FAIL ei_pre got %b want 0", mon_a.err_flag);
                    else passes++;
                end
                prev = mon_a.rx_data;
            end
        end
        checks++;
        if (!found) $display("FAIL ei_timeout got none want 7f->81");
        else passes++;
        step();
        checks++;
        if (mon_a.err_flag !== 1'b1 || mon_a.err_count !== 5'd1 ||
            mon_a.leds[5] !== 1'b0)
            $display("FAIL ei_flag got %b/%0d/%b want 1/1/0",
                     mon_a.err_flag, mon_a.err_count, mon_a.leds[5]);
        else passes++;
        want = 8'h82;
        cyc = 0;
        while (n < 2 && cyc < 40) begin
            if (mon_a.rx_valid === 1'b1) begin
                checks++;
                if (mon_a.rx_data !== want)
                    $display("FAIL ei_next got %h want %h", mon_a.rx_data, want);
                else passes++;
                want = want + 8'd1;
                n++;
            end
            step();
            cyc++;
            checks++;
            if (mon_a.err_count !== 5'd1)
                $display("FAIL ei_count got %0d want 1", mon_a.err_count);
            else passes++;
        end
        checks++;
        if (n < 2) $display("FAIL ei_next_timeout got %0d want 2", n);
        else passes++;
    endtask
`endif

    task automatic test_mid_reset();
        int cyc = 0;
        bit seen = 0;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        while (mon_b.fifo_level != 5'd10 && cyc < 100) begin
            step();
            cyc++;
        end
        checks++;
        if (mon_b.fifo_level !== 5'd10)
            $display("FAIL mr_fill got %0d want 10", mon_b.fifo_level);
        else passes++;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        checks++;
        if (mon_b.fifo_level !== 5'd0 || mon_b.err_flag !== 1'b0 ||
            mon_b.rx_valid !== 1'b0)
            $display("FAIL mr_clear got %0d/%b/%b want 0/0/0",
                     mon_b.fifo_level, mon_b.err_flag, mon_b.rx_valid);
        else passes++;
        cyc = 0;
        while (!seen && cyc < 50) begin
            step();
            cyc++;
            checks++;
            if (mon_b.fifo_level !== 5'(qb.size()))
                $display("FAIL mr_level got %0d want %0d",
                         mon_b.fifo_level, qb.size());
            else passes++;
            if (mon_b.rx_valid === 1'b1) begin
                seen = 1;
                checks++;
                if (mon_b.rx_data !== 8'h00)
                    $display("FAIL mr_first got %h want 00", mon_b.rx_data);
                else passes++;
            end
        end
        checks++;
        if (!seen) $display("FAIL mr_timeout got none want rx_valid");
        else passes++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_push();
        test_full_stall();
        test_wrap();
`ifdef ERR_INJECT_EN
        test_err_inject();
`endif
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
